wb_regfile: RTL
===============

# wb_regfile

Write-back stage and register file for the SCU ISA pipelined CPU. The block consumes the EX/WB buffer's outputs and selects the write-back value (memory read data or ALU result). It commits that value to a 64-entry × 32-bit register file and latches the ALU N/Z condition flags used by branch resolution. It also serves the two combinational register read ports used by instruction decode, with same-cycle write bypass.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 6, register address width (2^ADDR_W = 64 registers)
- clock  in  1  system clock; all state updates on rising edge (EX/WB buffer updates on falling edge, so inputs are stable half a cycle before commit)
- reset  in  1  synchronous, active-high
- RegWrite_in  in  1  write enable from EX/WB buffer
- MemToReg_in  in  1  1 = write readData_in, 0 = write aluResult_in
- readData_in  in  DATA_W  data-memory read value
- aluResult_in  in  DATA_W  ALU result
- aluN_in, aluZ_in  in  1 each  ALU negative/zero flags
- rd_in  in  ADDR_W  destination register
- rs_addr, rt_addr  in  ADDR_W  decode read addresses
- rs_data, rt_data  out  DATA_W  read data (combinational)
- wb_data  out  DATA_W  selected write-back value (combinational)
- flagN, flagZ  out  1 each  latched condition flags
- wb_count  out  32  count of committed register writes

## Operation
- wb_data = MemToReg_in ? readData_in : aluResult_in, regardless of RegWrite_in.
- Commit: on a rising edge with reset=0, RegWrite_in=1 and rd_in≠0, regs[rd_in] ← wb_data and wb_count ← wb_count+1.
- Register 0 reads as 0. Writes to register 0 are discarded and do not increment wb_count.
- Flags: on a rising edge with reset=0, RegWrite_in=1 and MemToReg_in=0, flagN ← aluN_in and flagZ ← aluZ_in. Flags update even when rd_in=0, so compare-style ops targeting r0 still set flags. Loads (MemToReg_in=1) and RegWrite_in=0 leave flags unchanged.
- Read ports:
  - rs_data = 0 if rs_addr=0.
  - Otherwise rs_data = wb_data if RegWrite_in=1 and rd_in=rs_addr (bypass).
  - Otherwise rs_data = regs[rs_addr].
  - rt_data follows the same rules independently; both ports may bypass the same write.
- wb_count wraps from 2^32−1 to 0 with no flag.

## Timing
- Reset values:
  - all 64 registers = 0
  - flagN = 0, flagZ = 0
  - wb_count = 0
  - rs_data/rt_data/wb_data follow the combinational rules above, so they read 0 from the array after reset.
- Reset takes priority over any concurrent write or flag update. A reset asserted mid-stream clears state on that edge; the first write after deassertion commits on the next edge.
- Write latency: 0 cycles to the read ports through bypass; 1 edge into the array.
- Read-after-write to the same register on the following cycle sees the array value; there is no stale window.
- Back-to-back writes to the same rd: the last one wins, and each increments wb_count.

## Structure
- Shared package scu_pkg: DATA_W, ADDR_W, NUM_REGS=64, and the REG_ZERO=0 constant, shared with the decode stage and the EX/WB buffer.
- One sub-module, scu_flag_reg, holds the N/Z flag register with its enable. The array, bypass, write-back mux and counter stay in wb_regfile.

## Test plan
- Reset check: assert reset for 2 cycles, then read rs=5, rt=63 → both 0; flagN=flagZ=0; wb_count=0.
- ALU write: RegWrite=1, MemToReg=0, aluResult=0xDEADBEEF, rd=7, aluN=1, aluZ=0.
  - Same cycle, rs_addr=7 → rs_data=0xDEADBEEF (bypass).
  - Next cycle, with RegWrite=0 → rs_data still 0xDEADBEEF; flagN=1; wb_count=1.
- Load write: MemToReg=1, readData=0x12345678, aluResult=0xFFFFFFFF, rd=3 → regs[3]=0x12345678; flags unchanged; wb_count increments.
- r0 write: RegWrite=1, MemToReg=0, rd=0, aluResult=0x55, aluZ=1 → rs_addr=0 reads 0; wb_count unchanged; flagZ=1.
- Dual bypass and reset priority:
  - rs_addr=rt_addr=rd=9 with write 0xA5A5A5A5 → both ports show 0xA5A5A5A5.
  - Assert reset on the same edge as a write to r9 → regs[9]=0 and wb_count=0 afterwards.

Source files
------------

// File: rtl/scu_pkg.sv
// Shared SCU pipeline constants used by decode, the EX/WB buffer and write-back.
package scu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 64;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/scu_flag_reg.sv
// ALU N/Z condition flag register consumed by branch resolution.
module scu_flag_reg (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic n_in,
  input  logic z_in,
  output logic flagN,
  output logic flagZ
);
  logic r_n, r_z;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (en) begin
      r_n <= n_in;
      r_z <= z_in;
    end
  end

  assign flagN = r_n;
  assign flagZ = r_z;
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, 64x32 register file with bypassed read
// ports, condition flags and committed-write counter.
module wb_regfile
  import scu_pkg::*;
#(
  parameter int DATA_W = scu_pkg::DATA_W,
  parameter int ADDR_W = scu_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic [DATA_W-1:0] readData_in,
  input  logic [DATA_W-1:0] aluResult_in,
  input  logic              aluN_in,
  input  logic              aluZ_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              flagN,
  output logic              flagZ,
  output logic [31:0]       wb_count
);
  localparam int NREG  = 2 ** ADDR_W;
  localparam int NPORT = 2;

  logic [DATA_W-1:0]             r_regs [NREG];
  logic [31:0]                   r_count;
  logic [DATA_W-1:0]             w_wb;
  logic                          w_commit;
  logic [NPORT-1:0][ADDR_W-1:0]  w_raddr;
  logic [NPORT-1:0][DATA_W-1:0]  w_rdata;

  assign w_wb     = MemToReg_in ? readData_in : aluResult_in;
  assign w_commit = RegWrite_in && (rd_in != ADDR_W'(REG_ZERO));

  // r0 is never written after reset, so the array slot stays zero as well.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_count <= '0;
    end else if (w_commit) begin
      r_regs[rd_in] <= w_wb;
      r_count       <= r_count + 32'd1;
    end
  end

  assign w_raddr[0] = rs_addr;
  assign w_raddr[1] = rt_addr;

  // Bypass keys on RegWrite_in alone; the r0 case is caught by the first test.
  always_comb begin
    w_rdata = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (w_raddr[p] == ADDR_W'(REG_ZERO))
        w_rdata[p] = '0;
      else if (RegWrite_in && (rd_in == w_raddr[p]))
        w_rdata[p] = w_wb;
      else
        w_rdata[p] = r_regs[w_raddr[p]];
    end
  end

  scu_flag_reg u_flags (
    .clock (clock),
    .reset (reset),
    .en    (RegWrite_in && !MemToReg_in),
    .n_in  (aluN_in),
    .z_in  (aluZ_in),
    .flagN (flagN),
    .flagZ (flagZ)
  );

  assign rs_data  = w_rdata[0];
  assign rt_data  = w_rdata[1];
  assign wb_data  = w_wb;
  assign wb_count = r_count;
endmodule
